// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared op codes, state encoding and negate helper for muldiv
package mips_pkg;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   // Two's-complement negate of a 64-bit value
   function automatic logic [63:0] neg64(input logic [63:0] x);
      return ~x + 64'd1;
   endfunction

endpackage

// File: rtl/muldiv.sv
// rtl/muldiv.sv - iterative MIPS32 multiply/divide unit owning HI/LO
module muldiv
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [2:0]  i_op,
   input  logic [31:0] i_busA,
   input  logic [31:0] i_busB,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   md_state_t   state;
   logic [5:0]  cnt;
   logic [63:0] acc;      // product, or {remainder, quotient}
   logic [31:0] opa;      // magnitude of multiplicand (multiply only)
   logic [31:0] opb;      // magnitude of multiplier/divisor
   logic        sign_a;
   logic        sign_b;
   logic        is_div;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;

   logic        op_signed;
   logic        op_is_div;
   logic        op_arith;
   logic        in_div_zero;
   logic        in_sign_a;
   logic        in_sign_b;
   logic [31:0] in_mag_a;
   logic [31:0] in_mag_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] fix_prod;
   logic [31:0] fix_quot;
   logic [31:0] fix_rem;

   // Operand preparation at launch: magnitudes and sign flags. A zero divisor
   // keeps the raw dividend so the remainder comes back exactly as given.
   always_comb begin
      op_signed   = (i_op == OP_MULT) || (i_op == OP_DIV);
      op_is_div   = (i_op == OP_DIV) || (i_op == OP_DIVU);
      op_arith    = (i_op == OP_MULT) || (i_op == OP_MULTU) || op_is_div;
      in_div_zero = op_is_div && (i_busB == 32'd0);
      in_sign_a   = op_signed && !in_div_zero && i_busA[31];
      in_sign_b   = op_signed && !in_div_zero && i_busB[31];
      in_mag_a    = in_sign_a ? (~i_busA + 32'd1) : i_busA;
      in_mag_b    = in_sign_b ? (~i_busB + 32'd1) : i_busB;
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
      mul_next = {mul_sum, acc[31:1]};
      div_ge   = (acc[63:31] >= {1'b0, opb});
      div_diff = acc[62:31] - opb;
      div_next = div_ge ? {div_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
   end

   // Sign correction applied in FIX; skipped entirely for divide by zero
   always_comb begin
      fix_prod = (sign_a ^ sign_b) ? neg64(acc) : acc;
      fix_quot = acc[31:0];
      fix_rem  = acc[63:32];
      if (!div_zero) begin
         if (sign_a ^ sign_b) fix_quot = ~acc[31:0] + 32'd1;
         if (sign_a)          fix_rem  = ~acc[63:32] + 32'd1;
      end
   end

   // Control FSM, datapath registers and architectural HI/LO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         cnt      <= 6'd0;
         acc      <= 64'd0;
         opa      <= 32'd0;
         opb      <= 32'd0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         is_div   <= 1'b0;
         div_zero <= 1'b0;
         hi       <= 32'd0;
         lo       <= 32'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  if (op_arith) begin
                     opa      <= in_mag_a;
                     opb      <= in_mag_b;
                     sign_a   <= in_sign_a;
                     sign_b   <= in_sign_b;
                     is_div   <= op_is_div;
                     div_zero <= in_div_zero;
                     acc      <= op_is_div ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
                     cnt      <= 6'd0;
                     state    <= ST_CALC;
                  end else if (i_op == OP_MTHI) begin
                     hi <= i_busA;
                  end else if (i_op == OP_MTLO) begin
                     lo <= i_busA;
                  end
               end
            end
            ST_CALC: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) state <= ST_FIX;
            end
            ST_FIX: begin
               if (is_div) begin
                  lo <= fix_quot;
                  hi <= fix_rem;
               end else begin
                  lo <= fix_prod[31:0];
                  hi <= fix_prod[63:32];
               end
               done  <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy   = (state != ST_IDLE);
   assign o_done   = done;
   assign o_result = (i_op == OP_MFHI) ? hi : lo;
   assign o_hi     = hi;
   assign o_lo     = lo;

endmodule

// File: tb/tb_muldiv.sv
// tb/tb_muldiv.sv - self-checking bench for muldiv
module tb_muldiv;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic [2:0]  i_op;
   logic [31:0] i_busA;
   logic [31:0] i_busB;
   logic        o_busy;
   logic        o_done;
   logic [31:0] o_result;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   muldiv dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_op     (i_op),
      .i_busA   (i_busA),
      .i_busB   (i_busB),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result),
      .o_hi     (o_hi),
      .o_lo     (o_lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Launch an op, track busy length, compare against the scoreboard at done.
   // With inject set, a second launch strobe is presented mid-CALC.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input bit inject);
      exp_t e;
      int   busy_cycles;
      int   n;
      @(negedge clk);
      i_op = op; i_busA = a; i_busB = b; i_start = 1'b1;
      e.tag = tag; e.hi = eh; e.lo = el;
      sb.push_back(e);
      @(negedge clk);
      i_start = 1'b0;
      busy_cycles = 0;
      n = 0;
      while (o_busy === 1'b1 && n < 100) begin
         busy_cycles++;
         if (inject && busy_cycles == 5) begin
            i_op = OP_MULTU; i_busA = 32'd3; i_busB = 32'd3; i_start = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      i_start = 1'b0;
      check({tag, " busy_cycles"}, busy_cycles, 32'd33);
      check({tag, " done"}, {31'd0, o_done}, 32'd1);
      e = sb.pop_front();
      check({e.tag, " hi"}, o_hi, e.hi);
      check({e.tag, " lo"}, o_lo, e.lo);
      i_op = OP_MFHI; #1;
      check({e.tag, " mfhi"}, o_result, e.hi);
      i_op = OP_MFLO; #1;
      check({e.tag, " mflo"}, o_result, e.lo);
      @(negedge clk);
      check({tag, " done_drop"}, {31'd0, o_done}, 32'd0);
   endtask

   initial begin
      int done_seen;
      int busy_seen;
      rst = 1'b1; i_start = 1'b0; i_op = OP_MFLO; i_busA = '0; i_busB = '0;
      repeat (2) @(negedge clk);
      check("reset busy", {31'd0, o_busy}, 32'd0);
      check("reset done", {31'd0, o_done}, 32'd0);
      check("reset hi", o_hi, 32'd0);
      check("reset lo", o_lo, 32'd0);
      rst = 1'b0;

      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b0);
      run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0);
      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
      run_op("div_mixed", OP_DIV, 32'd20, 32'hFFFFFFFD, 32'd2, 32'hFFFFFFFA, 1'b0);
      run_op("divu_inject", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);

      // MTHI then MTLO: single-cycle writes, never busy
      busy_seen = 0;
      done_seen = 0;
      @(negedge clk);
      i_op = OP_MTHI; i_busA = 32'hA5A5A5A5; i_start = 1'b1;
      @(negedge clk);
      busy_seen += int'(o_busy); done_seen += int'(o_done);
      check("mthi hi", o_hi, 32'hA5A5A5A5);
      i_op = OP_MTLO; i_busA = 32'h5A5A5A5A;
      @(negedge clk);
      busy_seen += int'(o_busy); done_seen += int'(o_done);
      i_start = 1'b0;
      i_op = OP_MFHI; #1;
      check("mfhi after mt", o_result, 32'hA5A5A5A5);
      i_op = OP_MFLO; #1;
      check("mflo after mt", o_result, 32'h5A5A5A5A);
      @(negedge clk);
      busy_seen += int'(o_busy); done_seen += int'(o_done);
      check("mt busy", busy_seen, 32'd0);
      check("mt done", done_seen, 32'd0);

      // Reset in the middle of a DIV
      @(negedge clk);
      i_op = OP_DIV; i_busA = 32'd1000; i_busB = 32'd3; i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      check("mid div busy", {31'd0, o_busy}, 32'd1);
      rst = 1'b1; #1;
      check("async rst busy", {31'd0, o_busy}, 32'd0);
      check("async rst hi", o_hi, 32'd0);
      check("async rst lo", o_lo, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_seen = 0;
      busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         done_seen += int'(o_done);
         busy_seen += int'(o_busy);
      end
      check("post rst done", done_seen, 32'd0);
      check("post rst busy", busy_seen, 32'd0);
      run_op("mult_after_rst", OP_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0);

      check("scoreboard empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the MIPS32 execute stage, owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from the ID/EX side, computes over 33 cycles, and raises o_busy so the hazard logic stalls the front of the pipeline. It serves MFHI/MFLO results onto the EX result bus that feeds the EX/MEM register (i_busC), and executes MTHI/MTLO in a single cycle.

## Interface
- No parameters; operand width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  launch/write strobe for MULT/MULTU/DIV/DIVU/MTHI/MTLO; sampled only in IDLE
- i_op  in  3  operation code (package constants)
- i_busA  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data
- i_busB  in  32  rt operand: multiplier or divisor
- o_busy  out  1  high while a multiply/divide is in flight; drives the pipeline stall
- o_done  out  1  one-cycle pulse in the cycle after HI/LO are updated by MULT*/DIV*
- o_result  out  32  HI when i_op=MFHI, LO otherwise; combinational from HI/LO
- o_hi, o_lo  out  32  architectural HI/LO, for debug/trace

## Operation
- States: IDLE, CALC, FIX. o_busy = (state != IDLE).
- IDLE, i_start, op in {MULT,MULTU,DIV,DIVU}:
  - Latch |A| and |B|, or raw values for unsigned ops.
  - Latch the result-sign flags.
  - Clear the 6-bit counter and go to CALC.
- IDLE, i_start, MTHI/MTLO: write i_busA into HI/LO at that edge. Stay in IDLE. No busy, no done.
- i_start in CALC/FIX is ignored. MFHI/MFLO never need i_start.
- CALC, multiply:
  - Radix-2 shift-add on a 64-bit product register, one multiplier bit per cycle, LSB first.
- CALC, divide:
  - Restoring division on a 64-bit {remainder, quotient} register.
  - Each cycle: shift left, trial-subtract the divisor from the upper 33 bits, set the quotient LSB if the result is non-negative.
- CALC exit: after 32 iterations (counter = 31), go to FIX.
- FIX:
  - Apply signs (two's-complement negate).
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: the quotient takes the XOR of the operand signs; the remainder takes the dividend's sign.
  - Write HI/LO, assert o_done next cycle, return to IDLE.
- Mapping: MULT* writes HI=product[63:32], LO=product[31:0]. DIV* writes LO=quotient, HI=remainder.
- Divide by zero (both signednesses): LO=0xFFFFFFFF, HI=dividend (i_busA as given). This falls out of the unsigned algorithm; the FIX stage must skip sign correction when the divisor is zero.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Reset: state=IDLE, HI=LO=0, counter=0, o_done=0, o_busy=0. Any in-flight operation is discarded.

## Timing
- Launch edge = E0.
- o_busy high from after E0 through the cycle before E33 (33 cycles).
- CALC iterations occur on E1..E32; FIX occupies E32–E33, and HI/LO update at E33.
- o_done high for exactly the cycle after E33, with o_busy already low.
- A new launch is accepted at E33.
- o_result follows HI/LO combinationally: MFHI issued in the cycle after E33 sees the new value.
- Back-to-back MTHI then MFHI: the new value is visible the cycle after the MTHI edge.
- MTHI/MTLO have 1-cycle latency.

## Structure
- Shared package (mips_pkg), op constants:
  - OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3
  - OP_MFHI=4, OP_MFLO=5, OP_MTHI=6, OP_MTLO=7
- Shared package, state encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
- Single module; no sub-module required. A 64-bit two's-complement negate helper function in the package is permitted.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> o_busy 33 cycles; at E33 HI=0xFFFFFFFE, LO=0x00000001; o_done one cycle.
- MULT −3 × 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x1234 / 0 -> LO=0xFFFFFFFF, HI=0x1234. DIV 0x80000000 / −1 -> LO=0x80000000, HI=0.
- MTHI 0xA5A5A5A5, then MTLO 0x5A5A5A5A -> o_busy never rises; MFHI/MFLO return those values. A second i_start mid-CALC is ignored and the first result is unaffected.
- Assert rst at cycle 10 of a DIV -> o_busy=0 and HI=LO=0 immediately; o_done never pulses; a fresh MULT afterward completes normally.
